// File: rtl/tia_hsync_counter.sv
// Horizontal sync counter driven by the TIA biphase clock (hphi1/hphi2).
// Optional phase-sequence checking is built when TIA_HSYNC_ERR_CHECK_EN is defined.
module tia_hsync_counter #(
   parameter int unsigned PERIOD      = 57,
   parameter int unsigned HSYNC_START = 4,
   parameter int unsigned HSYNC_END   = 8,
   parameter int unsigned HBLANK_END  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hphi1,
   input  logic       hphi2,
   input  logic       rsync_strobe,
   output logic [5:0] count,
   output logic [5:0] lfsr,
   output logic       hsync,
   output logic       hblank,
   output logic       adv,
   output logic       rsyn,
   output logic       phase_err
);

   localparam logic [1:0] S_WAIT_PHI1 = 2'd0;
   localparam logic [1:0] S_IN_PHI1   = 2'd1;
   localparam logic [1:0] S_WAIT_PHI2 = 2'd2;
   localparam logic [1:0] S_IN_PHI2   = 2'd3;

   localparam logic [5:0] CNT_LAST    = 6'(PERIOD - 1);
   localparam logic [5:0] CNT_HS_ON   = 6'(HSYNC_START);
   localparam logic [5:0] CNT_HS_OFF  = 6'(HSYNC_END);
   localparam logic [5:0] CNT_HB_OFF  = 6'(HBLANK_END);

   logic [1:0] state_q, state_d;
   logic [5:0] count_q, count_d;
   logic [5:0] lfsr_q, lfsr_d;
   logic       hsync_q, hsync_d;
   logic       hblank_q, hblank_d;
   logic       adv_q, adv_d;
   logic       rsyn_q, rsyn_d;

   logic       phi1_s;
   logic       phi2_s;
   logic       advance;
   logic       err_set;

   // Only a clean logic 1 counts as asserted; 0/z/x all read as deasserted.
   assign phi1_s = (hphi1 === 1'b1);
`ifdef TIA_HSYNC_ERR_CHECK_EN
   assign phi2_s = (hphi2 === 1'b1);
`else
   // Both-high collapses to phi1 alone when no checking is built.
   assign phi2_s = (hphi2 === 1'b1) && !phi1_s;
`endif

   always_comb begin
      state_d = state_q;
      advance = 1'b0;
      err_set = 1'b0;
      case (state_q)
         S_WAIT_PHI1: begin
`ifdef TIA_HSYNC_ERR_CHECK_EN
            if (phi2_s)
               err_set = 1'b1;
            else if (phi1_s)
               state_d = S_IN_PHI1;
`else
            if (phi1_s)
               state_d = S_IN_PHI1;
`endif
         end
         S_IN_PHI1: begin
`ifdef TIA_HSYNC_ERR_CHECK_EN
            if (phi1_s && phi2_s)
               err_set = 1'b1;
            else if (!phi1_s)
               state_d = S_WAIT_PHI2;
`else
            if (!phi1_s)
               state_d = S_WAIT_PHI2;
`endif
         end
         S_WAIT_PHI2: begin
`ifdef TIA_HSYNC_ERR_CHECK_EN
            if (phi1_s)
               err_set = 1'b1;
            else if (phi2_s)
               state_d = S_IN_PHI2;
`else
            if (phi2_s)
               state_d = S_IN_PHI2;
`endif
         end
         default: begin
`ifdef TIA_HSYNC_ERR_CHECK_EN
            if (phi1_s)
               err_set = 1'b1;
            else if (!phi2_s) begin
               advance = 1'b1;
               state_d = S_WAIT_PHI1;
            end
`else
            if (!phi2_s) begin
               advance = 1'b1;
               state_d = S_WAIT_PHI1;
            end
`endif
         end
      endcase
      if (err_set)
         state_d = S_WAIT_PHI1;
   end

   // Counter, LFSR image and registered decodes; the strobe overrides any advance.
   always_comb begin
      count_d  = count_q;
      lfsr_d   = lfsr_q;
      hsync_d  = hsync_q;
      hblank_d = hblank_q;
      adv_d    = 1'b0;
      rsyn_d   = 1'b0;
      if (rsync_strobe) begin
         count_d  = '0;
         lfsr_d   = '0;
         hsync_d  = 1'b0;
         hblank_d = 1'b1;
         rsyn_d   = 1'b1;
      end else if (advance) begin
         adv_d = 1'b1;
         if (count_q == CNT_LAST) begin
            count_d = '0;
            lfsr_d  = '0;
         end else begin
            count_d = count_q + 6'd1;
            lfsr_d  = {lfsr_q[4:0], ~(lfsr_q[5] ^ lfsr_q[4])};
         end
         if (count_d == CNT_HS_ON)
            hsync_d = 1'b1;
         else if (count_d == CNT_HS_OFF)
            hsync_d = 1'b0;
         if (count_d == '0)
            hblank_d = 1'b1;
         else if (count_d == CNT_HB_OFF)
            hblank_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_WAIT_PHI1;
         count_q  <= '0;
         lfsr_q   <= '0;
         hsync_q  <= 1'b0;
         hblank_q <= 1'b1;
         adv_q    <= 1'b0;
         rsyn_q   <= 1'b0;
      end else begin
         state_q  <= rsync_strobe ? S_WAIT_PHI1 : state_d;
         count_q  <= count_d;
         lfsr_q   <= lfsr_d;
         hsync_q  <= hsync_d;
         hblank_q <= hblank_d;
         adv_q    <= adv_d;
         rsyn_q   <= rsyn_d;
      end
   end

`ifdef TIA_HSYNC_ERR_CHECK_EN
   logic phase_err_q;

   // Sticky: only reset clears it; a strobe leaves it alone.
   always_ff @(posedge clk) begin
      if (reset)
         phase_err_q <= 1'b0;
      else if (!rsync_strobe && err_set)
         phase_err_q <= 1'b1;
   end

   assign phase_err = phase_err_q;
`else
   assign phase_err = 1'b0;
`endif

   assign count  = count_q;
   assign lfsr   = lfsr_q;
   assign hsync  = hsync_q;
   assign hblank = hblank_q;
   assign adv    = adv_q;
   assign rsyn   = rsyn_q;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Directed bench for tia_hsync_counter: reset, full line, strobe, phase error, reset mid-pair.
module tb_tia_hsync_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       hphi1;
   logic       hphi2;
   logic       rsync_strobe;
   logic [5:0] count;
   logic [5:0] lfsr;
   logic       hsync;
   logic       hblank;
   logic       adv;
   logic       rsyn;
   logic       phase_err;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [5:0] m_count;
   logic [5:0] m_lfsr;

   tia_hsync_counter #(
      .PERIOD      (57),
      .HSYNC_START (4),
      .HSYNC_END   (8),
      .HBLANK_END  (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .hphi1        (hphi1),
      .hphi2        (hphi2),
      .rsync_strobe (rsync_strobe),
      .count        (count),
      .lfsr         (lfsr),
      .hsync        (hsync),
      .hblank       (hblank),
      .adv          (adv),
      .rsyn         (rsyn),
      .phase_err    (phase_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] lfsr_step(input logic [5:0] v);
      return {v[4:0], ~(v[5] ^ v[4])};
   endfunction

   // Model update on an advance; decodes are checked in closed form by check_line.
   task automatic model_adv();
      if (m_count == 6'd56) begin
         m_count = '0;
         m_lfsr  = '0;
      end else begin
         m_count = m_count + 6'd1;
         m_lfsr  = lfsr_step(m_lfsr);
      end
   endtask

   task automatic check_line(input string tag);
      chk({tag, ".count"},  32'(count),  32'(m_count));
      chk({tag, ".lfsr"},   32'(lfsr),   32'(m_lfsr));
      chk({tag, ".hsync"},  32'(hsync),  32'((m_count >= 6'd4) && (m_count < 6'd8)));
      chk({tag, ".hblank"}, 32'(hblank), 32'(m_count < 6'd16));
   endtask

   // Nominal pair: phi1, idle, phi2, idle; advance lands on the last edge.
   task automatic pair(input string tag);
      hphi1 = 1'b1; tick();
      chk({tag, ".adv_p1"}, 32'(adv), 32'd0);
      hphi1 = 1'b0; tick();
      hphi2 = 1'b1; tick();
      chk({tag, ".adv_p2"}, 32'(adv), 32'd0);
      hphi2 = 1'b0; tick();
      model_adv();
      chk({tag, ".adv"}, 32'(adv), 32'd1);
      check_line(tag);
   endtask

   initial begin
      reset = 1'b1; hphi1 = 1'b0; hphi2 = 1'b0; rsync_strobe = 1'b0;
      m_count = '0; m_lfsr = '0;
      tick(); tick();
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.lfsr", 32'(lfsr), 32'd0);
      chk("rst.hsync", 32'(hsync), 32'd0);
      chk("rst.hblank", 32'(hblank), 32'd1);
      chk("rst.adv", 32'(adv), 32'd0);
      chk("rst.rsyn", 32'(rsyn), 32'd0);
      chk("rst.perr", 32'(phase_err), 32'd0);
      reset = 1'b0;
      tick();
      chk("idle.count", 32'(count), 32'd0);

      // T1/T2: one full line plus the wrap
      for (int i = 1; i <= 57; i++) begin
         pair("t1");
         if (i == 1) chk("t1.lfsr1", 32'(lfsr), 32'h01);
         if (i == 2) chk("t1.lfsr2", 32'(lfsr), 32'h03);
         if (i == 4) chk("t2.hs_on", 32'(hsync), 32'd1);
         if (i == 8) chk("t2.hs_off", 32'(hsync), 32'd0);
         if (i == 16) chk("t2.hb_off", 32'(hblank), 32'd0);
      end
      chk("t1.wrap_count", 32'(count), 32'd0);
      chk("t1.wrap_lfsr", 32'(lfsr), 32'd0);
      chk("t2.wrap_hblank", 32'(hblank), 32'd1);

      // T3: strobe at count 30
      for (int i = 0; i < 30; i++) pair("t3pre");
      chk("t3.at30", 32'(count), 32'd30);
      rsync_strobe = 1'b1; tick(); rsync_strobe = 1'b0;
      m_count = '0; m_lfsr = '0;
      chk("t3.count", 32'(count), 32'd0);
      chk("t3.lfsr", 32'(lfsr), 32'd0);
      chk("t3.hblank", 32'(hblank), 32'd1);
      chk("t3.hsync", 32'(hsync), 32'd0);
      chk("t3.rsyn", 32'(rsyn), 32'd1);
      tick();
      chk("t3.rsyn_off", 32'(rsyn), 32'd0);
      pair("t3post");
      chk("t3.next1", 32'(count), 32'd1);

      // T4: strobe coincident with the advancing edge at count 10
      for (int i = 0; i < 9; i++) pair("t4pre");
      chk("t4.at10", 32'(count), 32'd10);
      hphi1 = 1'b1; tick();
      hphi1 = 1'b0; tick();
      hphi2 = 1'b1; tick();
      hphi2 = 1'b0; rsync_strobe = 1'b1; tick(); rsync_strobe = 1'b0;
      m_count = '0; m_lfsr = '0;
      chk("t4.count", 32'(count), 32'd0);
      chk("t4.adv", 32'(adv), 32'd0);
      chk("t4.rsyn", 32'(rsyn), 32'd1);
      pair("t4post");
      chk("t4.next1", 32'(count), 32'd1);

      // T5: both phases high for one clk at count 5
      for (int i = 0; i < 4; i++) pair("t5pre");
      chk("t5.at5", 32'(count), 32'd5);
      hphi1 = 1'b1; hphi2 = 1'b1; tick();
      hphi1 = 1'b0; hphi2 = 1'b0;
      chk("t5.count_hold", 32'(count), 32'd5);
`ifdef TIA_HSYNC_ERR_CHECK_EN
      chk("t5.perr", 32'(phase_err), 32'd1);
      tick();
      pair("t5post");
      chk("t5.count6", 32'(count), 32'd6);
      chk("t5.perr_sticky", 32'(phase_err), 32'd1);
`else
      chk("t5.perr", 32'(phase_err), 32'd0);
      tick();
      hphi2 = 1'b1; tick();
      hphi2 = 1'b0; tick();
      m_count = 6'd6; m_lfsr = lfsr_step(m_lfsr);
      chk("t5.adv", 32'(adv), 32'd1);
      chk("t5.count6", 32'(count), 32'd6);
      chk("t5.perr_low", 32'(phase_err), 32'd0);
`endif

      // T6: reset while in IN_PHI2 at count 20
      for (int i = 0; i < 14; i++) pair("t6pre");
      chk("t6.at20", 32'(count), 32'd20);
      hphi1 = 1'b1; tick();
      hphi1 = 1'b0; tick();
      hphi2 = 1'b1; tick();
      hphi2 = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
      m_count = '0; m_lfsr = '0;
      chk("t6.count", 32'(count), 32'd0);
      chk("t6.adv", 32'(adv), 32'd0);
      chk("t6.hblank", 32'(hblank), 32'd1);
      chk("t6.perr", 32'(phase_err), 32'd0);
      tick();
      chk("t6.idle_adv", 32'(adv), 32'd0);
      pair("t6post");
      chk("t6.next1", 32'(count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
